// File: rtl/digit_pkg.sv
// Shared types and helpers for the button-driven digit counters.
// The debounce state encoding and the debounce counter width live here.
package digit_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      HELD      = 2'd2,
      RELEASING = 2'd3
   } dbState_e;

   // The counter must be able to hold DEBOUNCE_CYCLES itself.
   function automatic int unsigned dbCntWidth(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage : digit_pkg

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM for one raw push-button.
// Emits a single-cycle press when a high level has been stable long enough.
module btn_debounce
   import digit_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press,
   output logic level
);

   localparam int unsigned   CW     = dbCntWidth(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CntOne = CW'(1);

   if (DEBOUNCE_CYCLES < 1) begin : gBadCycles
      $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
   end

   logic          sync1_q, sync2_q;
   dbState_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   // A level change is only accepted once the counter already holds
   // DEBOUNCE_CYCLES stable samples and the level is still stable.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = ARMING;
               cnt_d   = CntOne;
            end
         end
         ARMING: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = HELD;
               cnt_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               state_d = RELEASING;
               cnt_d   = CntOne;
            end
         end
         RELEASING: begin
            if (sync2_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;
   assign level = (state_q == HELD) || (state_q == RELEASING);

endmodule : btn_debounce

// File: rtl/mod_counter_db.sv
// Mod-N digit counter stepped by a debounced button or a chained step_in.
// Carry/borrow pulses let digits cascade into multi-digit fields.
module mod_counter_db
   import digit_pkg::*;
#(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned RESET_VAL       = 0,
   parameter int unsigned WRAP_VAL        = 1,
   parameter int unsigned MAX_VAL         = 3,
   parameter int unsigned SET_VAL         = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn,
   input  logic             step_in,
   input  logic             dir,
   input  logic             set,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             carry,
   output logic             borrow,
   output logic             press
);

   if ((WRAP_VAL > MAX_VAL) || (longint'(MAX_VAL) >= (longint'(1) << WIDTH)) ||
       (SET_VAL > MAX_VAL) || (RESET_VAL > MAX_VAL)) begin : gBadParams
      $error("mod_counter_db: need WRAP_VAL <= MAX_VAL < 2**WIDTH, SET_VAL/RESET_VAL <= MAX_VAL");
   end

   localparam logic [WIDTH-1:0] MaxV   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] WrapV  = WIDTH'(WRAP_VAL);
   localparam logic [WIDTH-1:0] SetV   = WIDTH'(SET_VAL);
   localparam logic [WIDTH-1:0] ResetV = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] One    = WIDTH'(1);

   logic             btnPress, btnLevel, step;
   logic [WIDTH-1:0] count_q, count_d;
   logic             carry_q, carry_d;
   logic             borrow_q, borrow_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) uDebounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn),
      .press(btnPress),
      .level(btnLevel)
   );

   // A press only ever fires on entry to the held level, so the gate is a
   // guard against stepping on anything but an accepted level.
   assign step = (btnPress && btnLevel) || step_in;

   always_comb begin
      count_d  = count_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      if (set) begin
         count_d = SetV;
      end else if (load) begin
         count_d = (load_val > MaxV) ? MaxV : load_val;
      end else if (step) begin
         if (dir) begin
            if (count_q >= MaxV) begin
               count_d = WrapV;
               carry_d = 1'b1;
            end else begin
               count_d = count_q + One;
            end
         end else begin
            if (count_q <= WrapV) begin
               count_d  = MaxV;
               borrow_d = 1'b1;
            end else begin
               count_d = count_q - One;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= ResetV;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
      end
   end

   assign count  = count_q;
   assign carry  = carry_q;
   assign borrow = borrow_q;
   assign press  = btnPress;

endmodule : mod_counter_db

// File: tb/tb_mod_counter_db.sv
// Directed bench for mod_counter_db: default digit plus a 3-bit, MAX_VAL=5
// instance used for load clamping.
module tb_mod_counter_db;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0, stepIn = 1'b0, dir = 1'b1, set = 1'b0, load = 1'b0;
   logic [1:0] loadVal = '0;
   logic [1:0] count;
   logic       carry, borrow, press;

   logic       btnB = 1'b0, stepInB = 1'b0, dirB = 1'b1, setB = 1'b0, loadB = 1'b0;
   logic [2:0] loadValB = '0;
   logic [2:0] countB;
   logic       carryB, borrowB, pressB;

   int total = 0;
   int bad = 0;
   int pressSeen;
   int carrySeen;

   always #5 clock = ~clock;

   mod_counter_db uDut (
      .clk(clock), .rst(rst), .btn(btn), .step_in(stepIn), .dir(dir), .set(set),
      .load(load), .load_val(loadVal), .count(count), .carry(carry),
      .borrow(borrow), .press(press)
   );

   mod_counter_db #(.WIDTH(3), .MAX_VAL(5)) uDutB (
      .clk(clock), .rst(rst), .btn(btnB), .step_in(stepInB), .dir(dirB), .set(setB),
      .load(loadB), .load_val(loadValB), .count(countB), .carry(carryB),
      .borrow(borrowB), .press(pressB)
   );

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      logic [1:0] expPress [4];
      expPress = '{2'd1, 2'd2, 2'd3, 2'd1};

      applyStimulus(2);
      checkOutput("rst_count", 8'(count), 8'd0);
      checkOutput("rst_carry", 8'(carry), 8'd0);
      checkOutput("rst_borrow", 8'(borrow), 8'd0);
      checkOutput("rst_press", 8'(press), 8'd0);
      rst = 1'b0;

      // Four clean presses: 0->1->2->3->1, carry only on the wrap.
      for (int i = 0; i < 4; i++) begin
         pressSeen = 0;
         carrySeen = 0;
         btn = 1'b1;
         for (int k = 0; k < 8; k++) begin
            applyStimulus(1);
            pressSeen += int'(press);
            carrySeen += int'(carry);
         end
         btn = 1'b0;
         for (int k = 0; k < 8; k++) begin
            applyStimulus(1);
            pressSeen += int'(press);
            carrySeen += int'(carry);
         end
         checkOutput($sformatf("press%0d_count", i), 8'(count), 8'(expPress[i]));
         checkOutput($sformatf("press%0d_npress", i), 8'(pressSeen), 8'd1);
         checkOutput($sformatf("press%0d_carry", i), 8'(carrySeen), (i == 3) ? 8'd1 : 8'd0);
      end

      // Glitches of 1..3 high samples, then a real 10-cycle hold.
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      pressSeen = 0;
      for (int g = 1; g <= 3; g++) begin
         btn = 1'b1;
         for (int k = 0; k < g; k++) begin
            applyStimulus(1);
            pressSeen += int'(press);
         end
         btn = 1'b0;
         for (int k = 0; k < 4; k++) begin
            applyStimulus(1);
            pressSeen += int'(press);
         end
      end
      checkOutput("glitch_npress", 8'(pressSeen), 8'd0);
      checkOutput("glitch_count", 8'(count), 8'd0);
      btn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1);
         pressSeen += int'(press);
         if (k == 5 || k == 6 || k == 7)
            checkOutput($sformatf("hold_press_e%0d", k), 8'(press), (k == 6) ? 8'd1 : 8'd0);
      end
      btn = 1'b0;
      applyStimulus(8);
      checkOutput("hold_npress", 8'(pressSeen), 8'd1);
      checkOutput("hold_count", 8'(count), 8'd1);

      // Down-steps from 3 with borrow on 1->3.
      set = 1'b1;
      applyStimulus(1);
      set = 1'b0;
      checkOutput("set_count", 8'(count), 8'd3);
      dir = 1'b0;
      stepIn = 1'b1;
      applyStimulus(1);
      checkOutput("dn_3to2", 8'(count), 8'd2);
      checkOutput("dn_3to2_borrow", 8'(borrow), 8'd0);
      applyStimulus(1);
      checkOutput("dn_2to1", 8'(count), 8'd1);
      checkOutput("dn_2to1_borrow", 8'(borrow), 8'd0);
      applyStimulus(1);
      stepIn = 1'b0;
      checkOutput("dn_1to3", 8'(count), 8'd3);
      checkOutput("dn_1to3_borrow", 8'(borrow), 8'd1);
      checkOutput("dn_1to3_carry", 8'(carry), 8'd0);
      applyStimulus(1);
      checkOutput("borrow_oneshot", 8'(borrow), 8'd0);
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      checkOutput("rst2_count", 8'(count), 8'd0);
      stepIn = 1'b1;
      applyStimulus(1);
      stepIn = 1'b0;
      checkOutput("dn_0to3", 8'(count), 8'd3);
      checkOutput("dn_0to3_borrow", 8'(borrow), 8'd1);

      // set/load beat a simultaneous step and suppress carry.
      dir = 1'b1;
      load = 1'b1;
      loadVal = 2'd1;
      applyStimulus(1);
      load = 1'b0;
      checkOutput("load1", 8'(count), 8'd1);
      set = 1'b1;
      stepIn = 1'b1;
      applyStimulus(1);
      set = 1'b0;
      checkOutput("set_vs_step", 8'(count), 8'd3);
      checkOutput("set_vs_step_carry", 8'(carry), 8'd0);
      load = 1'b1;
      loadVal = 2'd2;
      applyStimulus(1);
      load = 1'b0;
      stepIn = 1'b0;
      checkOutput("load_vs_step", 8'(count), 8'd2);
      checkOutput("load_vs_step_carry", 8'(carry), 8'd0);

      loadB = 1'b1;
      loadValB = 3'd7;
      applyStimulus(1);
      checkOutput("b_clamp", 8'(countB), 8'd5);
      loadValB = 3'd4;
      applyStimulus(1);
      loadB = 1'b0;
      checkOutput("b_load4", 8'(countB), 8'd4);
      stepInB = 1'b1;
      applyStimulus(2);
      stepInB = 1'b0;
      checkOutput("b_wrap", 8'(countB), 8'd1);
      checkOutput("b_wrap_carry", 8'(carryB), 8'd1);

      // Press and step_in in the same cycle step only once.
      load = 1'b1;
      loadVal = 2'd1;
      applyStimulus(1);
      load = 1'b0;
      btn = 1'b1;
      applyStimulus(7);
      checkOutput("coin_press", 8'(press), 8'd1);
      stepIn = 1'b1;
      applyStimulus(1);
      stepIn = 1'b0;
      checkOutput("coin_count", 8'(count), 8'd2);
      checkOutput("coin_carry", 8'(carry), 8'd0);
      btn = 1'b0;
      applyStimulus(8);

      // Reset in ARMING with the button still held; re-debounced afterwards.
      btn = 1'b1;
      applyStimulus(4);
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      checkOutput("rstarm_count", 8'(count), 8'd0);
      checkOutput("rstarm_press", 8'(press), 8'd0);
      pressSeen = 0;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1);
         pressSeen += int'(press);
         if (k == D + 3)
            checkOutput("rstarm_press_edge", 8'(press), 8'd1);
      end
      checkOutput("rstarm_npress", 8'(pressSeen), 8'd1);
      checkOutput("rstarm_count_after", 8'(count), 8'd1);
      btn = 1'b0;
      applyStimulus(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mod_counter_db
